// File: rtl/snake_pkg.sv
// snake_pkg: direction encoding and helpers shared by the snake input path.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    // Reversal pairs differ only in the upper bit: up<->down, right<->left.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_btn_cond.sv
// snake_btn_cond: one button bit -> 2-flop synchronizer, counter debouncer and
// rising-edge press pulse. The press pulse is registered together with the
// level, so it is high in the first cycle the new level is visible.
module snake_btn_cond #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; flip the level once it has
    // lasted DB_CYCLES cycles. Any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: debounced 4-button direction input feeding a small command
// queue that the game tick drains.
// Optional build macro SNAKE_INPUT_REVERSE_FILTER_EN: only presses perpendicular
// to the last queued direction are accepted (no repeats, no reversals).
module snake_input_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 500000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          RstN,
    input  logic [3:0]                    Btn,
    input  logic                          Pop,
    output logic                          CmdValid,
    output logic [1:0]                    CmdDir,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic [3:0]                    BtnLevel,
    output logic                          Overflow
);

    // FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap for free.
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

    logic [3:0]    press;
    dir_t          press_dir;
    logic          press_any;
    logic          dir_ok;
    logic          push_req, push_en, pop_en, drop;

    dir_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        snake_btn_cond #(
            .DB_CYCLES (DB_CYCLES)
        ) u_cond (
            .clk_i   (Clk),
            .rst_ni  (RstN),
            .raw_i   (Btn[i]),
            .level_o (BtnLevel[i]),
            .press_o (press[i])
        );
    end

    // Resolve simultaneous presses: lowest bit index wins, the rest are dropped.
    always_comb begin
        press_any = |press;
        press_dir = DIR_UP;
        if (press[0]) begin
            press_dir = DIR_UP;
        end else if (press[1]) begin
            press_dir = DIR_RIGHT;
        end else if (press[2]) begin
            press_dir = DIR_DOWN;
        end else if (press[3]) begin
            press_dir = DIR_LEFT;
        end
    end

`ifdef SNAKE_INPUT_REVERSE_FILTER_EN
    dir_t last_q;

    // Last tracks the tail; once drained the tail is also the last popped entry.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            last_q <= DIR_RIGHT;
        end else if (push_en) begin
            last_q <= press_dir;
        end
    end

    assign dir_ok = (press_dir != last_q) && (press_dir != opposite(last_q));
`else
    assign dir_ok = 1'b1;
`endif

    // Queue control: a pop frees a slot for a same-cycle push; empty pops are ignored.
    always_comb begin
        pop_en     = Pop && (count_q != '0);
        push_req   = press_any && dir_ok;
        push_en    = push_req && ((count_q != CntFull) || pop_en);
        drop       = push_req && !push_en;
        wr_ptr_d   = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue control state register.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Command storage; contents are only observable through the masked head.
    always_ff @(posedge Clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= press_dir;
        end
    end

    assign CmdValid = (count_q != '0);
    // Mask the head while empty so stale or uninitialised storage never shows.
    assign CmdDir   = CmdValid ? mem_q[rd_ptr_q] : DIR_UP;
    assign Count    = count_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb_snake_input_ctrl: scenario tasks plus randomized traffic, all checked against
// a behavioural model (raw-sample history window + queue of directions).
module tb_snake_input_ctrl;

    localparam int DB    = 4;
    localparam int DEPTH = 4;
`ifdef SNAKE_INPUT_REVERSE_FILTER_EN
    localparam bit FilterEn = 1'b1;
`else
    localparam bit FilterEn = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       pop;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic [2:0] count;
    logic [3:0] btn_level;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [3:0] m_hist[$];
    logic [3:0] m_level;
    logic [3:0] m_press;
    logic [1:0] m_q[$];
    logic [1:0] m_last_pop;
    logic       m_ovf;

    snake_input_ctrl #(
        .DB_CYCLES  (DB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk      (clk),
        .RstN     (rst_n),
        .Btn      (btn),
        .Pop      (pop),
        .CmdValid (cmd_valid),
        .CmdDir   (cmd_dir),
        .Count    (count),
        .BtnLevel (btn_level),
        .Overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < DB + 2; i++) m_hist.push_back(4'b0);
        m_level    = 4'b0;
        m_press    = 4'b0;
        m_q.delete();
        m_last_pop = 2'd1;
        m_ovf      = 1'b0;
    endtask

    // One rising edge: queue reacts to last edge's presses, then debounce advances.
    task automatic model_edge(input logic [3:0] raw, input logic p);
        logic [1:0] last, d;
        logic [3:0] new_press;
        bit pop_ok, full, accept, stable;
        last   = (m_q.size() != 0) ? m_q[$] : m_last_pop;
        pop_ok = p && (m_q.size() != 0);
        full   = (m_q.size() == DEPTH);
        accept = 1'b0;
        d      = 2'd0;
        if (m_press != 4'b0) begin
            for (int b = 3; b >= 0; b--) if (m_press[b]) d = 2'(b);
            if (!FilterEn || (d != last && d != (last ^ 2'b10))) begin
                if (!full || pop_ok) accept = 1'b1;
                else m_ovf = 1'b1;
            end
        end
        if (pop_ok) m_last_pop = m_q.pop_front();
        if (accept) m_q.push_back(d);
        // Level flips once the input seen two edges late differs for DB edges in a row.
        m_hist.push_back(raw);
        new_press = 4'b0;
        for (int b = 0; b < 4; b++) begin
            stable = 1'b1;
            for (int j = 0; j < DB; j++)
                if (m_hist[m_hist.size() - 3 - j][b] == m_level[b]) stable = 1'b0;
            if (stable) begin
                new_press[b] = ~m_level[b];
                m_level[b]   = ~m_level[b];
            end
        end
        m_press = new_press;
        while (m_hist.size() > DB + 3) void'(m_hist.pop_front());
    endtask

    function automatic logic [1:0] m_head();
        return (m_q.size() != 0) ? m_q[0] : 2'd0;
    endfunction

    // Drive inputs at a falling edge, run one rising edge, return at the next falling edge.
    task automatic tick(input logic [3:0] b, input logic p);
        btn = b;
        pop = p;
        @(posedge clk);
        model_edge(b, p);
        @(negedge clk);
    endtask

    task automatic reset_assert();
        @(negedge clk);
        rst_n = 1'b0;
        btn   = 4'b0;
        pop   = 1'b0;
        #1;
    endtask

    task automatic reset_release();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Hold a button pattern long enough to register, optionally popping on the push edge.
    task automatic press_vec(input logic [3:0] v, input bit pop_with);
        int guard;
        if (pop_with) begin
            guard = 0;
            while (m_press == 4'b0 && guard < 20) begin
                tick(v, 1'b0);
                guard++;
            end
            checks++;
            if (m_press == 4'b0) begin
                errors++;
                $display("FAIL press_pulse_timeout: no press after %0d cycles, required within 20",
                         guard);
            end
            tick(v, 1'b1);
            repeat (2) tick(v, 1'b0);
        end else begin
            repeat (DB + 4) tick(v, 1'b0);
        end
        repeat (DB + 4) tick(4'b0, 1'b0);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", cmd_valid); end
        if (cmd_dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d required 0", cmd_dir); end
        if (btn_level !== 4'b0) begin errors++; $display("FAIL reset_level: got %b required 0000", btn_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", overflow); end
        reset_release();
    endtask

    task automatic test_glitch();
        reset_assert();
        reset_release();
        for (int n = 0; n < 14; n++) begin
            tick((n < 2) ? 4'b0001 : 4'b0000, 1'b0);
            checks += 2;
            if (btn_level !== m_level) begin
                errors++; $display("FAIL glitch_level: got %b required %b", btn_level, m_level);
            end
            if (count !== 3'(m_q.size())) begin
                errors++; $display("FAIL glitch_count: got %0d required %0d", count, m_q.size());
            end
        end
        checks++;
        if (btn_level !== 4'b0 || count !== 3'd0) begin
            errors++; $display("FAIL glitch_final: level %b count %0d required 0000/0", btn_level, count);
        end
    endtask

    task automatic test_hold();
        int rise_at;
        reset_assert();
        reset_release();
        rise_at = -1;
        for (int n = 1; n <= 20; n++) begin
            tick(4'b0001, 1'b0);
            if (btn_level[0] && rise_at < 0) rise_at = n;
            if (rise_at > 0 && n == rise_at + 1) begin
                checks += 3;
                if (cmd_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b required 1", cmd_valid); end
                if (cmd_dir !== 2'd0) begin errors++; $display("FAIL hold_dir: got %0d required 0", cmd_dir); end
                if (count !== 3'd1) begin errors++; $display("FAIL hold_count: got %0d required 1", count); end
            end
        end
        checks++;
        if (rise_at != 2 + DB) begin
            errors++; $display("FAIL hold_latency: got %0d required %0d", rise_at, 2 + DB);
        end
        repeat (DB + 4) tick(4'b0, 1'b0);
    endtask

    task automatic test_filter();
        reset_assert();
        reset_release();
        press_vec(4'b1000, 1'b0);
        checks++;
        if (count !== 3'(m_q.size()) || count !== (FilterEn ? 3'd0 : 3'd1)) begin
            errors++; $display("FAIL filter_left: got %0d required %0d", count, m_q.size());
        end
        press_vec(4'b0100, 1'b0);
        checks += 2;
        if (count !== 3'(m_q.size())) begin
            errors++; $display("FAIL filter_down: got %0d required %0d", count, m_q.size());
        end
        if (cmd_dir !== m_head()) begin
            errors++; $display("FAIL filter_head: got %0d required %0d", cmd_dir, m_head());
        end
        press_vec(4'b0001, 1'b0);
        checks++;
        if (count !== 3'(m_q.size()) || count !== (FilterEn ? 3'd1 : 3'd3)) begin
            errors++; $display("FAIL filter_up: got %0d required %0d", count, m_q.size());
        end
    endtask

    task automatic test_overflow();
        reset_assert();
        reset_release();
        press_vec(4'b0001, 1'b0);
        press_vec(4'b1000, 1'b0);
        press_vec(4'b0100, 1'b0);
        press_vec(4'b0010, 1'b0);
        press_vec(4'b0001, 1'b0);
        checks += 2;
        if (count !== 3'd4 || count !== 3'(m_q.size())) begin
            errors++; $display("FAIL ovf_count: got %0d required 4", count);
        end
        if (overflow !== 1'b1 || overflow !== m_ovf) begin
            errors++; $display("FAIL ovf_flag: got %b required 1", overflow);
        end
        press_vec(4'b0001, 1'b1);
        checks += 3;
        if (count !== 3'd4 || count !== 3'(m_q.size())) begin
            errors++; $display("FAIL ovf_pushpop_count: got %0d required 4", count);
        end
        if (cmd_dir !== m_head()) begin
            errors++; $display("FAIL ovf_pushpop_head: got %0d required %0d", cmd_dir, m_head());
        end
        if (overflow !== m_ovf) begin
            errors++; $display("FAIL ovf_sticky: got %b required %b", overflow, m_ovf);
        end
    endtask

    task automatic test_simultaneous();
        reset_assert();
        reset_release();
        press_vec(4'b0110, 1'b0);
        checks += 2;
        if (count !== 3'd1 || count !== 3'(m_q.size())) begin
            errors++; $display("FAIL simul_count: got %0d required 1", count);
        end
        if (cmd_dir !== 2'd1 || cmd_dir !== m_head()) begin
            errors++; $display("FAIL simul_dir: got %0d required 1", cmd_dir);
        end
    endtask

    task automatic test_reset_mid();
        reset_assert();
        reset_release();
        press_vec(4'b0001, 1'b0);
        press_vec(4'b1000, 1'b0);
        press_vec(4'b0100, 1'b0);
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL mid_precount: got %0d required 3", count); end
        reset_assert();
        checks += 3;
        if (count !== 3'd0) begin errors++; $display("FAIL mid_async_count: got %0d required 0", count); end
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b required 0", cmd_valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL mid_async_ovf: got %b required 0", overflow); end
        reset_release();
        press_vec(4'b1000, 1'b0);
        checks++;
        if (count !== 3'(m_q.size()) || count !== (FilterEn ? 3'd0 : 3'd1)) begin
            errors++; $display("FAIL mid_left: got %0d required %0d", count, m_q.size());
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        int hold;
        reset_assert();
        reset_release();
        for (int seg = 0; seg < 80; seg++) begin
            v    = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, DB + 6);
            for (int n = 0; n < hold; n++) begin
                tick(v, ($urandom_range(0, 3) == 0));
                checks += 5;
                if (btn_level !== m_level) begin
                    errors++; $display("FAIL rand_level: got %b required %b", btn_level, m_level);
                end
                if (count !== 3'(m_q.size())) begin
                    errors++; $display("FAIL rand_count: got %0d required %0d", count, m_q.size());
                end
                if (cmd_valid !== (m_q.size() != 0)) begin
                    errors++; $display("FAIL rand_valid: got %b required %b", cmd_valid, m_q.size() != 0);
                end
                if (cmd_dir !== m_head()) begin
                    errors++; $display("FAIL rand_dir: got %0d required %0d", cmd_dir, m_head());
                end
                if (overflow !== m_ovf) begin
                    errors++; $display("FAIL rand_ovf: got %b required %b", overflow, m_ovf);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        btn   = 4'b0;
        pop   = 1'b0;
        model_reset();
        test_reset();
        test_glitch();
        test_hold();
        test_filter();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
